microcode_sequencer: RTL and testbench
======================================

Name: microcode_sequencer

Overview:
- Next-address controller for the microcode store: drives its `address`, consumes the decoded control fields and sequences execution.
- Supports linear step, forced jump, conditional branch on a variable or timer, computed switch jump, and subroutine call/return via an internal return stack.
- Sits between the microcode store and the variable/timer/switch sources; gates execution on the store's `ready`.

Parameters:
NUM_ADDRESS_LINES, 5, width of microcode address
NUM_VARSEL_BITS, 3, width of variable select; NUM_VARS = 2**NUM_VARSEL_BITS
NUM_TIMERS, 1, number of timer-done inputs (>=1)
SWITCH_WIDTH, 3, width of switch offset added to jadr
STACK_DEPTH, 4, return-stack entries (>=1)
START_ADDR, 0, address loaded on start

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
start  in  1  begin execution from START_ADDR (IDLE/FAULT only)
halt_req  in  1  stop execution, return to IDLE
ready  in  1  microcode store loaded
jadr  in  NUM_ADDRESS_LINES  jump target field
varSel  in  NUM_VARSEL_BITS  condition select
var_or_timer  in  1  0 = test vars, 1 = test timer_done
branch  in  1  conditional branch
forced_jmp  in  1  unconditional jump
sub  in  1  call
rtn  in  1  return
switch_active  in  1  computed jump
vars  in  NUM_VARS  condition variables
timer_done  in  NUM_TIMERS  timer expiry flags
switch_data  in  SWITCH_WIDTH  switch offset
address  out  NUM_ADDRESS_LINES  microcode address, registered
busy  out  1  1 in RUN
fault  out  1  1 in FAULT
stack_depth  out  clog2(STACK_DEPTH+1)  entries in use

Behaviour:
- Reset (rst=0, async): state=IDLE, address=START_ADDR, stack_depth=0, busy=0, fault=0. Stack contents don't-care.
- States: IDLE, RUN, FAULT; busy/fault decoded registered from state.
- IDLE:
  - start=1 & ready=1 -> RUN, address<=START_ADDR, stack_depth<=0.
  - start=1 & ready=0 is ignored.
- RUN: control fields are combinational from the store at the current address. One instruction per cycle. Priority, first match applies:
  1. halt_req -> IDLE, address held.
  2. ready=0 -> IDLE, address<=START_ADDR.
  3. rtn:
     - stack_depth=0 -> FAULT, address held.
     - otherwise address<=top, pop.
  4. sub:
     - stack_depth=STACK_DEPTH -> FAULT, address held.
     - otherwise push address+1, address<=jadr.
  5. forced_jmp -> address<=jadr.
  6. branch:
     - cond = var_or_timer ? timer_done[varSel] : vars[varSel].
     - cond=1 -> jadr, else address+1.
     - varSel>=NUM_TIMERS with var_or_timer=1 -> cond=0.
  7. switch_active -> address<=jadr+switch_data (zero-extended).
  8. else address<=address+1.
- Arithmetic: all address sums are mod 2**NUM_ADDRESS_LINES, so the last word +1 wraps to 0. The pushed return value wraps the same way.
- Simultaneous flags: only the highest-priority action occurs. Example: rtn+sub = return only, no push.
- FAULT: address and stack frozen. start=1 & ready=1 -> RUN as from IDLE, which clears the stack; otherwise stay.
- Stack: LIFO, push/pop single-cycle. stack_depth updates the same edge as address.
- No combinational path from inputs to outputs.

Test Plan:
- Reset then start with ready=1, all fields 0 -> address 0,1,2,…,31,0 (wrap); busy=1; stack_depth=0.
- Branch at addr 4, jadr=20, varSel=2, var_or_timer=0:
  - vars[2]=1 -> next address 20.
  - vars[2]=0 -> next address 5.
  - Repeat with var_or_timer=1 and timer_done[0] at varSel=0.
- sub at 3 (jadr=10), sub at 11 (jadr=16), rtn at 17, rtn at 13:
  - address sequence 3,10,11,16,17,12,13,4.
  - stack_depth goes 1,2,1,0.
- STACK_DEPTH=4: five nested subs -> fifth causes fault=1, busy=0, address frozen, stack_depth=4. Then start -> RUN at 0, stack_depth=0.
- rtn with empty stack -> FAULT. Also: sub+rtn same cycle -> treated as rtn.
- switch_active with jadr=28, switch_data=5 -> address 1 (wrap). halt_req mid-RUN -> IDLE, address held. rst asserted mid-RUN -> address 0 immediately.

Source files
------------

// File: rtl/microcode_sequencer.sv
// Next-address controller for a microcode store: linear step, jumps, conditional
// branches, computed switch jumps and subroutine call/return via a return stack.
module microcode_sequencer #(
  parameter int NUM_ADDRESS_LINES = 5,
  parameter int NUM_VARSEL_BITS   = 3,
  parameter int NUM_TIMERS        = 1,
  parameter int SWITCH_WIDTH      = 3,
  parameter int STACK_DEPTH       = 4,
  parameter int START_ADDR        = 0,
  localparam int NUM_VARS = 2**NUM_VARSEL_BITS,
  localparam int DEPTH_W  = $clog2(STACK_DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         halt_req,
  input  logic                         ready,
  input  logic [NUM_ADDRESS_LINES-1:0] jadr,
  input  logic [NUM_VARSEL_BITS-1:0]   varSel,
  input  logic                         var_or_timer,
  input  logic                         branch,
  input  logic                         forced_jmp,
  input  logic                         sub,
  input  logic                         rtn,
  input  logic                         switch_active,
  input  logic [NUM_VARS-1:0]          vars,
  input  logic [NUM_TIMERS-1:0]        timer_done,
  input  logic [SWITCH_WIDTH-1:0]      switch_data,
  output logic [NUM_ADDRESS_LINES-1:0] address,
  output logic                         busy,
  output logic                         fault,
  output logic [DEPTH_W-1:0]           stack_depth
);

  localparam int AW    = NUM_ADDRESS_LINES;
  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [AW-1:0]      START = AW'(START_ADDR);
  localparam logic [DEPTH_W-1:0] FULL  = DEPTH_W'(STACK_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FLT} state_t;

  state_t              state, state_next;
  logic [AW-1:0]       addr_next;
  logic [DEPTH_W-1:0]  depth_next;
  logic                push;
  logic                cond;
  logic [AW-1:0]       stack_mem [STACK_DEPTH];
  logic [PTR_W-1:0]    top_idx, push_idx;
  logic [AW-1:0]       addr_inc;

  assign top_idx  = PTR_W'(stack_depth - 1'b1);
  assign push_idx = PTR_W'(stack_depth);
  assign addr_inc = address + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      address     <= START;
      stack_depth <= '0;
    end else begin
      state       <= state_next;
      address     <= addr_next;
      stack_depth <= depth_next;
    end
  end

  // Stack contents need no reset; only stack_depth qualifies them.
  always_ff @(posedge clk) begin
    if (push) stack_mem[push_idx] <= addr_inc;
  end

  // Timer selects beyond NUM_TIMERS read as a false condition.
  always_comb begin
    cond = 1'b0;
    if (var_or_timer) begin
      for (int unsigned t = 0; t < NUM_TIMERS; t++)
        if (32'(varSel) == t) cond = timer_done[t];
    end else begin
      cond = vars[varSel];
    end
  end

  always_comb begin
    state_next = state;
    addr_next  = address;
    depth_next = stack_depth;
    push       = 1'b0;
    unique case (state)
      IDLE, FLT: begin
        if (start && ready) begin
          state_next = RUN;
          addr_next  = START;
          depth_next = '0;
        end
      end
      RUN: begin
        if (halt_req) begin
          state_next = IDLE;
        end else if (!ready) begin
          state_next = IDLE;
          addr_next  = START;
        end else if (rtn) begin
          if (stack_depth == '0) begin
            state_next = FLT;
          end else begin
            addr_next  = stack_mem[top_idx];
            depth_next = stack_depth - 1'b1;
          end
        end else if (sub) begin
          if (stack_depth == FULL) begin
            state_next = FLT;
          end else begin
            push       = 1'b1;
            addr_next  = jadr;
            depth_next = stack_depth + 1'b1;
          end
        end else if (forced_jmp) begin
          addr_next = jadr;
        end else if (branch) begin
          addr_next = cond ? jadr : addr_inc;
        end else if (switch_active) begin
          addr_next = jadr + AW'(switch_data);
        end else begin
          addr_next = addr_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == RUN);
    fault = (state == FLT);
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed, table-driven check of the microcode sequencer with default parameters.
module tb_microcode_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, halt_req, ready, var_or_timer, branch, forced_jmp, sub, rtn, switch_active;
  logic [4:0] jadr;
  logic [2:0] varSel;
  logic [7:0] vars;
  logic [0:0] timer_done;
  logic [2:0] switch_data;
  logic [4:0] address;
  logic       busy, fault;
  logic [2:0] stack_depth;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  microcode_sequencer #(
    .NUM_ADDRESS_LINES(5), .NUM_VARSEL_BITS(3), .NUM_TIMERS(1),
    .SWITCH_WIDTH(3), .STACK_DEPTH(4), .START_ADDR(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .ready(ready),
    .jadr(jadr), .varSel(varSel), .var_or_timer(var_or_timer), .branch(branch),
    .forced_jmp(forced_jmp), .sub(sub), .rtn(rtn), .switch_active(switch_active),
    .vars(vars), .timer_done(timer_done), .switch_data(switch_data),
    .address(address), .busy(busy), .fault(fault), .stack_depth(stack_depth)
  );

  // ctl bits: {start, halt, branch, forced_jmp, sub, rtn, switch_active}
  localparam logic [6:0] C_NONE = 7'b0000000, C_START = 7'b1000000, C_HALT = 7'b0100000,
                         C_BR = 7'b0010000, C_FJ = 7'b0001000, C_SUB = 7'b0000100,
                         C_RTN = 7'b0000010, C_SW = 7'b0000001;

  typedef struct {
    logic [6:0] ctl;
    logic [4:0] jadr;
    logic [2:0] vsel;
    logic       vot;
    logic [7:0] vars;
    logic       tmr;
    logic [2:0] swd;
    logic       rdy;
    logic [4:0] ea;
    logic       eb;
    logic       ef;
    logic [2:0] ed;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic [6:0] ctl, input logic [4:0] j, input logic [2:0] vs,
                     input logic vot, input logic [7:0] vr, input logic tm, input logic [2:0] sd,
                     input logic rdy, input logic [4:0] ea, input logic eb, input logic ef,
                     input logic [2:0] ed);
    vec_t v;
    v.ctl = ctl; v.jadr = j; v.vsel = vs; v.vot = vot; v.vars = vr; v.tmr = tm;
    v.swd = sd; v.rdy = rdy; v.ea = ea; v.eb = eb; v.ef = ef; v.ed = ed;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    {start, halt_req, branch, forced_jmp, sub, rtn, switch_active} = v.ctl;
    jadr = v.jadr; varSel = v.vsel; var_or_timer = v.vot; vars = v.vars;
    timer_done = v.tmr; switch_data = v.swd; ready = v.rdy;
  endtask

  task automatic check(input string name, input int idx, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s step %0d: got %0d want %0d", name, idx, got, want);
    end
  endtask

  task automatic check_all(input int idx, input logic [4:0] ea, input logic eb,
                           input logic ef, input logic [2:0] ed);
    check("address", idx, int'(address), int'(ea));
    check("busy", idx, int'(busy), int'(eb));
    check("fault", idx, int'(fault), int'(ef));
    check("stack_depth", idx, int'(stack_depth), int'(ed));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  vec_t idle_v;

  initial begin
    idle_v = '{C_NONE, 5'd0, 3'd0, 1'b0, 8'd0, 1'b0, 3'd0, 1'b1, 5'd0, 1'b0, 1'b0, 3'd0};
    rst = 1'b0;
    drive(idle_v);
    #12;
    check_all(-1, 5'd0, 1'b0, 1'b0, 3'd0);
    rst = 1'b1;
    #1;

    // Start, then free-run through all 32 words and wrap to 0.
    start = 1'b1;
    step;
    start = 1'b0;
    check_all(0, 5'd0, 1'b1, 1'b0, 3'd0);
    for (int i = 1; i <= 32; i++) begin
      step;
      check("wrap_addr", i, int'(address), i % 32);
      check("wrap_busy", i, int'(busy), 1);
    end

    //  ctl              jadr vsel vot vars      tmr swd rdy  addr busy flt depth
    add(C_NONE,          0,  0, 0, 8'h00,    0, 0, 1,   1, 1, 0, 0);
    add(C_NONE,          0,  0, 0, 8'h00,    0, 0, 1,   2, 1, 0, 0);
    add(C_NONE,          0,  0, 0, 8'h00,    0, 0, 1,   3, 1, 0, 0);
    add(C_SUB,          10,  0, 0, 8'h00,    0, 0, 1,  10, 1, 0, 1);
    add(C_NONE,          0,  0, 0, 8'h00,    0, 0, 1,  11, 1, 0, 1);
    add(C_SUB,          16,  0, 0, 8'h00,    0, 0, 1,  16, 1, 0, 2);
    add(C_NONE,          0,  0, 0, 8'h00,    0, 0, 1,  17, 1, 0, 2);
    add(C_RTN,           0,  0, 0, 8'h00,    0, 0, 1,  12, 1, 0, 1);
    add(C_NONE,          0,  0, 0, 8'h00,    0, 0, 1,  13, 1, 0, 1);
    add(C_RTN,           0,  0, 0, 8'h00,    0, 0, 1,   4, 1, 0, 0);
    add(C_BR,           20,  2, 0, 8'h04,    0, 0, 1,  20, 1, 0, 0);
    add(C_FJ,            4,  0, 0, 8'h00,    0, 0, 1,   4, 1, 0, 0);
    add(C_BR,           20,  2, 0, 8'hFB,    1, 0, 1,   5, 1, 0, 0);
    add(C_FJ,            4,  0, 0, 8'h00,    0, 0, 1,   4, 1, 0, 0);
    add(C_BR,           20,  0, 1, 8'h00,    1, 0, 1,  20, 1, 0, 0);
    add(C_FJ,            4,  0, 0, 8'h00,    0, 0, 1,   4, 1, 0, 0);
    add(C_BR,           20,  0, 1, 8'hFF,    0, 0, 1,   5, 1, 0, 0);
    add(C_BR,           20,  1, 1, 8'hFF,    1, 0, 1,   6, 1, 0, 0);
    add(C_SW,           28,  0, 0, 8'h00,    0, 5, 1,   1, 1, 0, 0);
    add(C_SUB|C_RTN,     9,  0, 0, 8'h00,    0, 0, 1,   1, 0, 1, 0);
    add(C_NONE,          0,  0, 0, 8'h00,    0, 0, 1,   1, 0, 1, 0);
    add(C_START,         0,  0, 0, 8'h00,    0, 0, 0,   1, 0, 1, 0);
    add(C_START,         0,  0, 0, 8'h00,    0, 0, 1,   0, 1, 0, 0);
    add(C_FJ,           31,  0, 0, 8'h00,    0, 0, 1,  31, 1, 0, 0);
    add(C_SUB,           2,  0, 0, 8'h00,    0, 0, 1,   2, 1, 0, 1);
    add(C_RTN,           0,  0, 0, 8'h00,    0, 0, 1,   0, 1, 0, 0);
    add(C_NONE,          0,  0, 0, 8'h00,    0, 0, 1,   1, 1, 0, 0);
    add(C_HALT|C_FJ,     7,  0, 0, 8'h00,    0, 0, 1,   1, 0, 0, 0);
    add(C_FJ,            7,  0, 0, 8'h00,    0, 0, 1,   1, 0, 0, 0);
    add(C_START,         0,  0, 0, 8'h00,    0, 0, 0,   1, 0, 0, 0);
    add(C_START,         0,  0, 0, 8'h00,    0, 0, 1,   0, 1, 0, 0);
    add(C_NONE,          0,  0, 0, 8'h00,    0, 0, 1,   1, 1, 0, 0);
    add(C_NONE,          0,  0, 0, 8'h00,    0, 0, 0,   0, 0, 0, 0);
    add(C_START,         0,  0, 0, 8'h00,    0, 0, 1,   0, 1, 0, 0);
    add(C_SUB,           5,  0, 0, 8'h00,    0, 0, 1,   5, 1, 0, 1);
    add(C_SUB,          10,  0, 0, 8'h00,    0, 0, 1,  10, 1, 0, 2);
    add(C_SUB,          15,  0, 0, 8'h00,    0, 0, 1,  15, 1, 0, 3);
    add(C_SUB,          20,  0, 0, 8'h00,    0, 0, 1,  20, 1, 0, 4);
    add(C_SUB,          25,  0, 0, 8'h00,    0, 0, 1,  20, 0, 1, 4);
    add(C_RTN,           0,  0, 0, 8'h00,    0, 0, 1,  20, 0, 1, 4);
    add(C_START,         0,  0, 0, 8'h00,    0, 0, 1,   0, 1, 0, 0);
    add(C_FJ|C_BR,       9,  0, 0, 8'h00,    0, 0, 1,   9, 1, 0, 0);
    add(C_BR|C_SW,       3,  0, 0, 8'h01,    0, 2, 1,   3, 1, 0, 0);
    add(C_NONE,          0,  0, 0, 8'h00,    0, 0, 1,   4, 1, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i]);
      step;
      check_all(100 + i, tbl[i].ea, tbl[i].eb, tbl[i].ef, tbl[i].ed);
    end

    // Asynchronous reset mid-RUN takes effect before the next edge.
    drive(idle_v);
    step;
    check("pre_reset_addr", 200, int'(address), 5);
    #2;
    rst = 1'b0;
    #1;
    check_all(201, 5'd0, 1'b0, 1'b0, 3'd0);
    rst = 1'b1;
    step;
    check_all(202, 5'd0, 1'b0, 1'b0, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
